apb_slave_ctrl: RTL and testbench
=================================

Name: apb_slave_ctrl

Overview:
- APB slave-side sequencer placed between the APB bus and the timer register block.
- Runs the APB SETUP/ACCESS handshake and inserts a configurable number of wait states.
- Checks the transfer address against the timer base window, then issues a single-cycle write or read strobe to the register block.
- Returns pready, prdata and pslverr to the bus. pslverr combines its own decode errors with the error flag reported by the register block.

Parameters:
- BASE_ADDR, 20'h40001, required value of paddr[31:12] for a valid access.
- WAIT_CYC, 0, wait states inserted before pready. Legal range is 0..15.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  APB address.
- pwdata  in  32  APB write data.
- pstrb  in  4  APB byte strobes.
- pready  out  1  transfer-complete.
- prdata  out  32  read data.
- pslverr  out  1  transfer error; valid only while pready=1.
- reg_wr_en  out  1  single-cycle write strobe to the register block.
- reg_rd_en  out  1  single-cycle read strobe to the register block.
- reg_addr  out  12  captured paddr[11:0].
- reg_wdata  out  32  captured pwdata.
- reg_pstrb  out  4  captured pstrb.
- reg_rdata  in  32  read data from the register block (combinational).
- reg_err  in  1  error flag from the register block (combinational, e.g. illegal TCR write).

Behaviour:
- Clock/reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst.
- Reset values:
  - state = IDLE, wait counter = 0.
  - pready, pslverr, reg_wr_en, reg_rd_en = 0.
  - prdata = 0; reg_addr, reg_wdata, reg_pstrb = 0.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - On psel=1 and penable=0, capture paddr[11:0], pwdata, pstrb, pwrite, and the address-OK flag.
  - address OK = (paddr[31:12]==BASE_ADDR) and (paddr[1:0]==0).
  - Next state is WAIT if WAIT_CYC>0, otherwise ACCESS. Counter is loaded with WAIT_CYC-1.
  - psel=1 with penable=1 while in IDLE (no setup phase) is ignored; stay in IDLE.
- WAIT:
  - pready=0.
  - If psel=0, abort: go to IDLE, no strobe issued.
  - Otherwise, when counter==0 go to ACCESS; else decrement.
- ACCESS (exactly one cycle):
  - Requires psel=1 and penable=1. If either is 0, abort to IDLE with pready=0 and no strobe.
  - Otherwise pready=1 for this cycle only.
  - If address OK: reg_wr_en=pwrite_q, reg_rd_en=~pwrite_q.
  - If address not OK: both strobes stay 0.
  - pslverr = ~addr_ok | (reg_err & reg_wr_en).
  - prdata = reg_rdata when reg_rd_en=1, otherwise 0.
  - Next state is always IDLE.
- Strobes, pready, pslverr and prdata are combinational decodes of state, so they are aligned in the same cycle. They are 0 in every state other than ACCESS.
- Latency: pready rises WAIT_CYC+1 cycles after the setup cycle. WAIT_CYC=0 gives standard zero-wait APB (pready in the first penable cycle).
- Back-to-back transfers: IDLE samples a new setup in the cycle right after ACCESS, so the minimum is 2 cycles per transfer.
- Captured fields hold until the next capture. Bus changes to pwdata/paddr during WAIT/ACCESS have no effect.
- reg_rd_en is never asserted together with reg_wr_en.
- Reset asserted mid-transfer: return to IDLE next edge with all outputs 0; no strobe is issued for the interrupted transfer.
- Counter: 4 bits. Out-of-range WAIT_CYC is a parameter error, checked at elaboration.

Test Plan:
- Write with WAIT_CYC=0, paddr=0x4000_100C, pwdata=0x1234_5678, pstrb=4'hF -> pready=1 and reg_wr_en=1 in the first penable cycle; reg_addr=0x00C, reg_wdata=0x1234_5678, pslverr=0.
- Read with WAIT_CYC=3, paddr=0x4000_1004, reg_rdata=0xA5A5_0001 -> pready low for 3 penable cycles, then high for 1 cycle with reg_rd_en=1 and prdata=0xA5A5_0001; prdata=0 on every other cycle.
- Bad base paddr=0x4000_2000 (write) and misaligned paddr=0x4000_1002 (read) -> pready=1, pslverr=1, reg_wr_en=reg_rd_en=0, prdata=0.
- Write with reg_err=1 during ACCESS, paddr=0x4000_1000 -> reg_wr_en=1, pslverr=1. Same with reg_err=1 on a read -> pslverr=0.
- Back-to-back write then read with WAIT_CYC=0 -> strobes exactly 2 cycles apart, each 1 cycle wide; second transfer uses its own captured address.
- sys_rst pulsed during WAIT (WAIT_CYC=5), and psel dropped during WAIT in a separate run -> FSM returns to IDLE; pready, reg_wr_en, reg_rd_en stay 0; the next full transfer completes normally.

Source files
------------

// File: rtl/apb_slave_ctrl.sv
// APB slave sequencer for the timer register block: SETUP/ACCESS handshake, WAIT_CYC wait states, window decode.
// pready rises WAIT_CYC+1 cycles after the setup cycle; the bus is stalled by holding pready low during WAIT.
module apb_slave_ctrl #(
  parameter logic [19:0] BASE_ADDR = 20'h40001,
  parameter int          WAIT_CYC  = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_pstrb,
  input  logic [31:0] reg_rdata,
  input  logic        reg_err
);

  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("apb_slave_ctrl: WAIT_CYC must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       pwrite_q;
  logic       addr_ok_q;
  logic       acc_ok;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pwrite_q  <= 1'b0;
      addr_ok_q <= 1'b0;
      reg_addr  <= 12'd0;
      reg_wdata <= 32'd0;
      reg_pstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // A select without a preceding setup phase is not a legal transfer start.
          if (psel && !penable) begin
            reg_addr  <= paddr[11:0];
            reg_wdata <= pwdata;
            reg_pstrb <= pstrb;
            pwrite_q  <= pwrite;
            addr_ok_q <= (paddr[31:12] == BASE_ADDR) && (paddr[1:0] == 2'b00);
            cnt       <= CNT_LOAD;
            state     <= (WAIT_CYC > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is decoded from state so strobes, pready and data line up in one cycle.
  assign acc_ok    = (state == ACCESS) && psel && penable && !sys_rst;
  assign pready    = acc_ok;
  assign reg_wr_en = acc_ok && addr_ok_q && pwrite_q;
  assign reg_rd_en = acc_ok && addr_ok_q && !pwrite_q;
  assign pslverr   = acc_ok && (!addr_ok_q || (reg_err && reg_wr_en));
  assign prdata    = reg_rd_en ? reg_rdata : 32'd0;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench for apb_slave_ctrl: three instances (WAIT_CYC 0, 3, 5) share the bus inputs.
module tb_apb_slave_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        psel, penable, pwrite, reg_err;
  logic [31:0] paddr, pwdata, reg_rdata;
  logic [3:0]  pstrb;

  logic [2:0]  pready, pslverr, reg_wr_en, reg_rd_en;
  logic [31:0] prdata    [3];
  logic [11:0] reg_addr  [3];
  logic [31:0] reg_wdata [3];
  logic [3:0]  reg_pstrb [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_ctrl #(
      .BASE_ADDR(20'h40001),
      .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .pready   (pready[g]),
      .prdata   (prdata[g]),
      .pslverr  (pslverr[g]),
      .reg_wr_en(reg_wr_en[g]),
      .reg_rd_en(reg_rd_en[g]),
      .reg_addr (reg_addr[g]),
      .reg_wdata(reg_wdata[g]),
      .reg_pstrb(reg_pstrb[g]),
      .reg_rdata(reg_rdata),
      .reg_err  (reg_err)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // {pready, reg_wr_en, reg_rd_en, pslverr} of instance d
  function automatic logic [3:0] ctl(input int d);
    return {pready[d], reg_wr_en[d], reg_rd_en[d], pslverr[d]};
  endfunction

  task automatic xfer(input string tag, input int d, input int waits, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] rdata, input logic err,
                      input logic exp_wr, input logic exp_rd, input logic exp_err,
                      input logic [31:0] exp_prdata);
    next_cyc();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    reg_rdata = rdata; reg_err = err;
    @(negedge sys_clk);
    chk({tag, "_setup_ctl"}, 32'(ctl(d)), 32'h0);
    next_cyc();
    penable = 1'b1;
    paddr = ~addr;
    pwdata = ~wdata;
    for (int k = 0; k < waits; k++) begin
      @(negedge sys_clk);
      chk({tag, "_wait_ctl"}, 32'(ctl(d)), 32'h0);
      chk({tag, "_wait_prdata"}, prdata[d], 32'h0);
      next_cyc();
    end
    @(negedge sys_clk);
    chk({tag, "_pready"}, 32'(pready[d]), 32'h1);
    chk({tag, "_wr_en"}, 32'(reg_wr_en[d]), 32'(exp_wr));
    chk({tag, "_rd_en"}, 32'(reg_rd_en[d]), 32'(exp_rd));
    chk({tag, "_pslverr"}, 32'(pslverr[d]), 32'(exp_err));
    chk({tag, "_prdata"}, prdata[d], exp_prdata);
    chk({tag, "_reg_addr"}, 32'(reg_addr[d]), 32'(addr[11:0]));
    chk({tag, "_reg_wdata"}, reg_wdata[d], wdata);
    chk({tag, "_reg_pstrb"}, 32'(reg_pstrb[d]), 32'(strb));
    next_cyc();
    psel = 1'b0; penable = 1'b0;
    @(negedge sys_clk);
    chk({tag, "_after_ctl"}, 32'(ctl(d)), 32'h0);
  endtask

  // Starts a transfer on instance 2 (WAIT_CYC=5) and leaves it two cycles into WAIT.
  task automatic start_into_wait(input string tag);
    next_cyc();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h4000_1000; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    reg_rdata = 32'h0; reg_err = 1'b0;
    next_cyc();
    penable = 1'b1;
    @(negedge sys_clk);
    chk({tag, "_wait1_ctl"}, 32'(ctl(2)), 32'h0);
    next_cyc();
    @(negedge sys_clk);
    chk({tag, "_wait2_ctl"}, 32'(ctl(2)), 32'h0);
  endtask

  task automatic hold_enabled_quiet(input string tag);
    next_cyc();
    psel = 1'b1; penable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      chk({tag, "_quiet_ctl"}, 32'(ctl(2)), 32'h0);
      next_cyc();
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; reg_rdata = 32'h0; reg_err = 1'b0;
    repeat (2) next_cyc();
    @(negedge sys_clk);
    chk("rst_ctl", 32'(ctl(0)), 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    chk("rst_reg_addr", 32'(reg_addr[0]), 32'h0);
    chk("rst_reg_wdata", reg_wdata[0], 32'h0);
    chk("rst_reg_pstrb", 32'(reg_pstrb[0]), 32'h0);
    next_cyc();
    sys_rst = 1'b0;

    xfer("wr0", 0, 0, 1'b1, 32'h4000_100C, 32'h1234_5678, 4'hF, 32'h0, 1'b0,
         1'b1, 1'b0, 1'b0, 32'h0);
    xfer("rd3", 1, 3, 1'b0, 32'h4000_1004, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0,
         1'b0, 1'b1, 1'b0, 32'hA5A5_0001);
    xfer("badbase", 0, 0, 1'b1, 32'h4000_2000, 32'h5555_AAAA, 4'h3, 32'h1111_2222, 1'b0,
         1'b0, 1'b0, 1'b1, 32'h0);
    xfer("misalign", 0, 0, 1'b0, 32'h4000_1002, 32'h0, 4'h0, 32'h3333_4444, 1'b0,
         1'b0, 1'b0, 1'b1, 32'h0);
    xfer("wr_regerr", 0, 0, 1'b1, 32'h4000_1000, 32'h0000_00FF, 4'h1, 32'h0, 1'b1,
         1'b1, 1'b0, 1'b1, 32'h0);
    xfer("rd_regerr", 0, 0, 1'b0, 32'h4000_1000, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1,
         1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);

    // Back-to-back on WAIT_CYC=0: write strobe, setup cycle, read strobe.
    next_cyc();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4000_1008; pwdata = 32'hCAFE_0001;
    pstrb = 4'hF; reg_rdata = 32'h7777_0008; reg_err = 1'b0;
    next_cyc();
    penable = 1'b1;
    @(negedge sys_clk);
    chk("b2b_wr_ctl", 32'(ctl(0)), 32'hC);
    chk("b2b_wr_addr", 32'(reg_addr[0]), 32'h008);
    next_cyc();
    penable = 1'b0; pwrite = 1'b0; paddr = 32'h4000_1010;
    @(negedge sys_clk);
    chk("b2b_gap_ctl", 32'(ctl(0)), 32'h0);
    next_cyc();
    penable = 1'b1;
    @(negedge sys_clk);
    chk("b2b_rd_ctl", 32'(ctl(0)), 32'hA);
    chk("b2b_rd_addr", 32'(reg_addr[0]), 32'h010);
    chk("b2b_rd_prdata", prdata[0], 32'h7777_0008);
    next_cyc();
    psel = 1'b0; penable = 1'b0;
    @(negedge sys_clk);
    chk("b2b_after_ctl", 32'(ctl(0)), 32'h0);

    // Synchronous reset in the middle of WAIT.
    start_into_wait("rstw");
    next_cyc();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rstw_rst_ctl", 32'(ctl(2)), 32'h0);
    next_cyc();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rstw_wdata_cleared", reg_wdata[2], 32'h0);
    hold_enabled_quiet("rstw");
    xfer("rstw_next", 2, 5, 1'b1, 32'h4000_1014, 32'h0102_0304, 4'h6, 32'h0, 1'b0,
         1'b1, 1'b0, 1'b0, 32'h0);

    // psel dropped in the middle of WAIT.
    start_into_wait("abort");
    next_cyc();
    psel = 1'b0; penable = 1'b0;
    @(negedge sys_clk);
    chk("abort_drop_ctl", 32'(ctl(2)), 32'h0);
    hold_enabled_quiet("abort");
    xfer("abort_next", 2, 5, 1'b0, 32'h4000_1018, 32'h0, 4'h0, 32'h9ABC_DEF0, 1'b0,
         1'b0, 1'b1, 1'b0, 32'h9ABC_DEF0);

    repeat (2) next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
